// File: rtl/multicycle_control_fsm.sv
// Multicycle main controller: one state per clock, Moore outputs (pc_write in BRANCH also depends on zero).
// Latency 3-5 cycles per instruction; MEM_RD/MEM_WR stall while mem_ready=0, HALT holds until rst.
module multicycle_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             SelectIns,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       PCSrc,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             BEQ,
  output logic             mem_req,
  output logic             halted,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_WB_ALU   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op_q;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_unused_op;

  // Only the class bit and the low bit of op_q matter after DECODE.
  assign w_unused_op = ^{r_op_q[5], r_op_q[3:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op_q    <= 6'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_op_q <= opcode;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (opcode[5:4])
          2'b00:   w_next = S_EXEC_R;
          2'b01:   w_next = S_EXEC_I;
          2'b10:   w_next = S_MEM_ADDR;
          default: begin
            case (opcode[1:0])
              2'b00, 2'b01: w_next = S_BRANCH;
              2'b10:        w_next = S_JUMP;
              default:      w_next = S_HALT;
            endcase
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = r_op_q[0] ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) w_next = S_FETCH;
      S_WB_ALU, S_MEM_WB, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end

  // HALT is reached from DECODE, so it can never count as a retirement.
  assign w_retire = (w_next == S_FETCH) &&
                    ((r_state == S_WB_ALU) || (r_state == S_MEM_WB) ||
                     (r_state == S_MEM_WR) || (r_state == S_BRANCH) ||
                     (r_state == S_JUMP));

  always_comb begin
    SelectIns = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    PCSrc     = 2'd0;
    RegWrite  = 1'b0;
    RegDst    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'd0;
    MemWrite  = 1'b0;
    MemtoReg  = 1'b0;
    BEQ       = 1'b0;
    mem_req   = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        S_EXEC_R: ALUSrcA = 1'b1;
        S_EXEC_I, S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
        end
        S_WB_ALU: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = r_op_q[4] ? 2'd2 : 2'd0;
          RegWrite = 1'b1;
          RegDst   = ~r_op_q[4];
        end
        S_MEM_RD: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'd2;
          mem_req = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        S_MEM_WR: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 2'd2;
          mem_req  = 1'b1;
          MemWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA  = 1'b1;
          BEQ      = r_op_q[0];
          PCSrc    = 2'd2;
          pc_write = zero ^ r_op_q[0];
        end
        S_JUMP: begin
          PCSrc    = 2'd2;
          pc_write = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

  assign state   = rst ? 4'd0 : r_state;
  assign retired = rst ? '0 : r_retired;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: each driven cycle pushes its expected state/controls/retired,
// popped and compared at the following falling edge.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        SelectIns, ir_write, pc_write, RegWrite, RegDst, ALUSrcA;
  logic        MemWrite, MemtoReg, BEQ, mem_req, halted;
  logic [1:0]  PCSrc, ALUSrcB;
  logic [3:0]  state;
  logic [15:0] retired;

  multicycle_control_fsm #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .SelectIns(SelectIns), .ir_write(ir_write), .pc_write(pc_write), .PCSrc(PCSrc),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .BEQ(BEQ), .mem_req(mem_req),
    .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2, S_EXEC_I = 4'd3,
                         S_WB_ALU = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_RD = 4'd6, S_MEM_WB = 4'd7,
                         S_MEM_WR = 4'd8, S_BRANCH = 4'd9, S_JUMP = 4'd10, S_HALT = 4'd11;

  typedef struct {
    int          idx;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc_idx = 0;
  logic [15:0] exp_ret = 16'd0;
  logic [14:0] obs_ctl;

  assign obs_ctl = {SelectIns, ir_write, pc_write, PCSrc, RegWrite, RegDst, ALUSrcA,
                    ALUSrcB, MemWrite, MemtoReg, BEQ, mem_req, halted};

  function automatic logic [14:0] ctl(input logic irw, input logic pcw, input logic [1:0] pcsrc,
                                      input logic rw, input logic rd, input logic asa,
                                      input logic [1:0] asb, input logic mw, input logic m2r,
                                      input logic beq, input logic mreq, input logic hlt);
    return {1'b0, irw, pcw, pcsrc, rw, rd, asa, asb, mw, m2r, beq, mreq, hlt};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("state@%0d", e.idx), {28'd0, state}, {28'd0, e.st});
      check($sformatf("ctl@%0d", e.idx), {17'd0, obs_ctl}, {17'd0, e.ctl});
      check($sformatf("retired@%0d", e.idx), {16'd0, retired}, {16'd0, e.ret});
    end
  end

  task automatic cyc(input logic r, input logic [5:0] op, input logic z, input logic mr,
                     input logic [3:0] st, input logic [14:0] c);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; opcode = op; zero = z; mem_ready = mr;
    e.idx = cyc_idx; e.st = st; e.ctl = c; e.ret = r ? 16'd0 : exp_ret;
    sb.push_back(e);
    cyc_idx++;
  endtask

  logic [14:0] c_fetch, c_exr, c_exi, c_wbr, c_wbi, c_mrd, c_mwb, c_mwr, c_jmp, c_halt;

  task automatic fetch_decode(input logic [5:0] op);
    cyc(0, op, 0, 1, S_FETCH, c_fetch);
    cyc(0, op, 0, 1, S_DECODE, 15'd0);
  endtask

  task automatic branch(input logic [5:0] op, input logic z);
    fetch_decode(op);
    cyc(0, op, z, 0, S_BRANCH, ctl(0, z ^ op[0], 2'd2, 0, 0, 1, 2'd0, 0, 0, op[0], 0, 0));
    exp_ret++;
  endtask

  initial begin
    c_fetch = ctl(1, 1, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    c_exr   = ctl(0, 0, 2'd0, 0, 0, 1, 2'd0, 0, 0, 0, 0, 0);
    c_exi   = ctl(0, 0, 2'd0, 0, 0, 1, 2'd2, 0, 0, 0, 0, 0);
    c_wbr   = ctl(0, 0, 2'd0, 1, 1, 1, 2'd0, 0, 0, 0, 0, 0);
    c_wbi   = ctl(0, 0, 2'd0, 1, 0, 1, 2'd2, 0, 0, 0, 0, 0);
    c_mrd   = ctl(0, 0, 2'd0, 0, 0, 1, 2'd2, 0, 0, 0, 1, 0);
    c_mwb   = ctl(0, 0, 2'd0, 1, 0, 0, 2'd0, 0, 1, 0, 0, 0);
    c_mwr   = ctl(0, 0, 2'd0, 0, 0, 1, 2'd2, 1, 0, 0, 1, 0);
    c_jmp   = ctl(0, 1, 2'd2, 0, 0, 0, 2'd0, 0, 0, 0, 0, 0);
    c_halt  = ctl(0, 0, 2'd0, 0, 0, 0, 2'd0, 0, 0, 0, 0, 1);

    cyc(1, 6'h00, 0, 0, S_FETCH, 15'd0);
    cyc(1, 6'h00, 0, 0, S_FETCH, 15'd0);

    // R-type
    fetch_decode(6'h00);
    cyc(0, 6'h00, 0, 1, S_EXEC_R, c_exr);
    cyc(0, 6'h00, 0, 1, S_WB_ALU, c_wbr);
    exp_ret++;

    // I-type
    fetch_decode(6'h10);
    cyc(0, 6'h10, 0, 0, S_EXEC_I, c_exi);
    cyc(0, 6'h10, 0, 0, S_WB_ALU, c_wbi);
    exp_ret++;

    // LW with three wait cycles
    fetch_decode(6'h20);
    cyc(0, 6'h20, 0, 1, S_MEM_ADDR, c_exi);
    for (int i = 0; i < 3; i++) cyc(0, 6'h20, 0, 0, S_MEM_RD, c_mrd);
    cyc(0, 6'h20, 0, 1, S_MEM_RD, c_mrd);
    cyc(0, 6'h20, 0, 0, S_MEM_WB, c_mwb);
    exp_ret++;

    // SW ready at once, then SW with one wait cycle
    fetch_decode(6'h21);
    cyc(0, 6'h21, 0, 0, S_MEM_ADDR, c_exi);
    cyc(0, 6'h21, 0, 1, S_MEM_WR, c_mwr);
    exp_ret++;
    fetch_decode(6'h21);
    cyc(0, 6'h21, 0, 1, S_MEM_ADDR, c_exi);
    cyc(0, 6'h21, 0, 0, S_MEM_WR, c_mwr);
    cyc(0, 6'h21, 0, 1, S_MEM_WR, c_mwr);
    exp_ret++;

    branch(6'h30, 1);
    branch(6'h30, 0);
    branch(6'h31, 0);
    branch(6'h31, 1);

    fetch_decode(6'h32);
    cyc(0, 6'h32, 0, 1, S_JUMP, c_jmp);
    exp_ret++;

    // opcode changes after DECODE must not affect the instruction in flight
    fetch_decode(6'h00);
    cyc(0, 6'h13, 0, 0, S_EXEC_R, c_exr);
    cyc(0, 6'h21, 0, 1, S_WB_ALU, c_wbr);
    exp_ret++;

    // reset while LW waits in MEM_RD
    fetch_decode(6'h20);
    cyc(0, 6'h20, 0, 0, S_MEM_ADDR, c_exi);
    cyc(0, 6'h20, 0, 0, S_MEM_RD, c_mrd);
    cyc(1, 6'h20, 0, 1, S_FETCH, 15'd0);
    exp_ret = 16'd0;
    fetch_decode(6'h00);
    cyc(0, 6'h00, 0, 0, S_EXEC_R, c_exr);
    cyc(0, 6'h00, 0, 0, S_WB_ALU, c_wbr);
    exp_ret++;

    fetch_decode(6'h33);
    for (int i = 0; i < 10; i++) cyc(0, 6'h33, i[0], i[1], S_HALT, c_halt);

    @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
